// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one multiplier core between two requesters.
// Round-robin grant, operand latching, start/done sequencing, a watchdog
// that aborts a hung multiplication, and a one-cycle ack per served request.
module mult_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req0,
  input  logic [WIDTH-1:0]     i_a0,
  input  logic [WIDTH-1:0]     i_b0,
  input  logic                 i_req1,
  input  logic [WIDTH-1:0]     i_a1,
  input  logic [WIDTH-1:0]     i_b1,
  output logic                 o_ack0,
  output logic                 o_ack1,
  output logic [2*WIDTH-1:0]   o_result,
  output logic                 o_err,
  output logic                 o_busy,
  output logic                 o_grant_id,
  output logic                 o_mul_start,
  output logic [WIDTH-1:0]     o_mul_a,
  output logic [WIDTH-1:0]     o_mul_b,
  input  logic                 i_mul_done,
  input  logic [2*WIDTH-1:0]   i_mul_product
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_RESP    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  // Abort fires when the incremented count reaches this value, so the ack of
  // an aborted job lands exactly TIMEOUT cycles after the start pulse.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_t               r_state;
  logic                 r_prio;
  logic [7:0]           r_count;
  logic                 r_ack0;
  logic                 r_ack1;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_err;
  logic                 r_busy;
  logic                 r_grant_id;
  logic                 r_mul_start;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;

  logic                 w_any_req;
  logic                 w_winner;
  logic [7:0]           w_cnt_next;
  logic                 w_req_granted;

  // Arbitration winner, watchdog increment and the served requester's level.
  always_comb begin
    w_any_req     = i_req0 | i_req1;
    w_winner      = 1'b0;
    w_cnt_next    = r_count + 8'd1;
    w_req_granted = 1'b0;
    if (i_req0 && i_req1) begin
      w_winner = r_prio;
    end else if (i_req1) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
    if (r_grant_id) begin
      w_req_granted = i_req1;
    end else begin
      w_req_granted = i_req0;
    end
  end

  // Control FSM; every output is registered and pulses default low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_prio      <= 1'b0;
      r_count     <= 8'd0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_grant_id  <= 1'b0;
      r_mul_start <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
    end else begin
      r_mul_start <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant_id  <= w_winner;
            r_mul_a     <= w_winner ? i_a1 : i_a0;
            r_mul_b     <= w_winner ? i_b1 : i_b0;
            r_mul_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_count <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_count <= w_cnt_next;
          // A done arriving on the abort cycle still delivers the product.
          if (i_mul_done) begin
            r_result <= i_mul_product;
            r_err    <= 1'b0;
            r_ack0   <= ~r_grant_id;
            r_ack1   <= r_grant_id;
            r_state  <= S_RESP;
          end else if (w_cnt_next == LP_CNT_LAST) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_ack0   <= ~r_grant_id;
            r_ack1   <= r_grant_id;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          r_prio  <= ~r_grant_id;
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          // Hold off until the served requester drops so it is not regranted.
          if (!w_req_granted) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_result    = r_result;
  assign o_err       = r_err;
  assign o_busy      = r_busy;
  assign o_grant_id  = r_grant_id;
  assign o_mul_start = r_mul_start;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed testbench for mult_share_arbiter with a 4-cycle core model.
module tb_mult_share_arbiter;

  logic        clk;
  logic        i_rst;
  logic        i_req0;
  logic [7:0]  i_a0;
  logic [7:0]  i_b0;
  logic        i_req1;
  logic [7:0]  i_a1;
  logic [7:0]  i_b1;
  logic        o_ack0;
  logic        o_ack1;
  logic [15:0] o_result;
  logic        o_err;
  logic        o_busy;
  logic        o_grant_id;
  logic        o_mul_start;
  logic [7:0]  o_mul_a;
  logic [7:0]  o_mul_b;
  logic        i_mul_done;
  logic [15:0] i_mul_product;

  logic        core_en;
  logic        force_done;
  logic        model_done;
  logic [2:0]  model_cnt;

  int n_total;
  int n_bad;

  mult_share_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_req0        (i_req0),
    .i_a0          (i_a0),
    .i_b0          (i_b0),
    .i_req1        (i_req1),
    .i_a1          (i_a1),
    .i_b1          (i_b1),
    .o_ack0        (o_ack0),
    .o_ack1        (o_ack1),
    .o_result      (o_result),
    .o_err         (o_err),
    .o_busy        (o_busy),
    .o_grant_id    (o_grant_id),
    .o_mul_start   (o_mul_start),
    .o_mul_a       (o_mul_a),
    .o_mul_b       (o_mul_b),
    .i_mul_done    (i_mul_done),
    .i_mul_product (i_mul_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: one-cycle done pulse four cycles after the start pulse.
  always @(posedge clk) begin
    if (i_rst) begin
      model_cnt  <= 3'd0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (core_en && o_mul_start) begin
        model_cnt <= 3'd3;
      end else if (model_cnt != 3'd0) begin
        model_cnt <= model_cnt - 3'd1;
        if (model_cnt == 3'd1) model_done <= 1'b1;
      end
    end
  end

  assign i_mul_done    = model_done | force_done;
  assign i_mul_product = 16'(o_mul_a) * 16'(o_mul_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for the ack of requester 'which'; cycle numbers count
  // from the cycle in which the task is entered.
  task automatic wait_ack(input logic which, output int start_cyc, output int ack_cyc,
                          output logic other_seen);
    start_cyc  = -1;
    ack_cyc    = -1;
    other_seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (o_mul_start && start_cyc < 0) start_cyc = n;
      if (which ? o_ack0 : o_ack1) other_seen = 1'b1;
      if (which ? o_ack1 : o_ack0) begin
        ack_cyc = n;
        break;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    i_rst = 1'b1;
    next_cycle();
    i_rst = 1'b0;
    next_cycle();
  endtask

  initial begin
    int   s_cyc;
    int   a_cyc;
    logic oth;
    logic any_ack;
    logic exp_id;

    n_total = 0;
    n_bad   = 0;
    i_rst = 1'b1;
    i_req0 = 1'b0; i_a0 = 8'd0; i_b0 = 8'd0;
    i_req1 = 1'b0; i_a1 = 8'd0; i_b1 = 8'd0;
    core_en = 1'b1;
    force_done = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_result", 32'(o_result), 32'd0);
    check_eq("rst_acks", 32'({o_ack0, o_ack1, o_mul_start, o_err}), 32'd0);
    next_cycle();
    i_rst = 1'b0;
    next_cycle();

    // Single request 7*9
    i_req0 = 1'b1; i_a0 = 8'd7; i_b0 = 8'd9;
    wait_ack(1'b0, s_cyc, a_cyc, oth);
    check_eq("single_start_cyc", 32'(s_cyc), 32'd1);
    check_eq("single_ack_cyc", 32'(a_cyc), 32'd6);
    check_eq("single_result", 32'(o_result), 32'd63);
    check_eq("single_err", 32'(o_err), 32'd0);
    check_eq("single_no_ack1", 32'(oth), 32'd0);
    next_cycle();
    i_req0 = 1'b0;
    @(negedge clk);
    check_eq("single_busy_release", 32'(o_busy), 32'd1);
    @(negedge clk);
    check_eq("single_busy_idle", 32'(o_busy), 32'd0);

    // Simultaneous requests from reset, alternation 0,1,0,1
    next_cycle();
    pulse_reset();
    i_req0 = 1'b1; i_a0 = 8'd3;   i_b0 = 8'd5;
    i_req1 = 1'b1; i_a1 = 8'd255; i_b1 = 8'd255;
    exp_id = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wait_ack(exp_id, s_cyc, a_cyc, oth);
      check_eq($sformatf("alt%0d_ack", j), 32'(a_cyc >= 0), 32'd1);
      check_eq($sformatf("alt%0d_grant", j), 32'(o_grant_id), 32'(exp_id));
      check_eq($sformatf("alt%0d_result", j), 32'(o_result), exp_id ? 32'h0000FE01 : 32'h0000000F);
      check_eq($sformatf("alt%0d_other_ack", j), 32'(oth), 32'd0);
      next_cycle();
      if (j == 3) begin
        i_req0 = 1'b0;
        i_req1 = 1'b0;
      end else if (exp_id) begin
        i_req1 = 1'b0;
      end else begin
        i_req0 = 1'b0;
      end
      next_cycle();
      if (j != 3) begin
        if (exp_id) i_req1 = 1'b1;
        else        i_req0 = 1'b1;
      end
      exp_id = ~exp_id;
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("alt_idle_busy", 32'(o_busy), 32'd0);

    // Operand stability: a0 changes two cycles after the grant
    next_cycle();
    i_req0 = 1'b1; i_a0 = 8'd12; i_b0 = 8'd10;
    next_cycle();
    next_cycle();
    i_a0 = 8'd100;
    wait_ack(1'b0, s_cyc, a_cyc, oth);
    check_eq("stable_mul_a", 32'(o_mul_a), 32'd12);
    check_eq("stable_result", 32'(o_result), 32'd120);
    next_cycle();
    i_req0 = 1'b0;
    next_cycle();

    // Watchdog abort, then a normal job
    core_en = 1'b0;
    next_cycle();
    i_req0 = 1'b1; i_a0 = 8'd5; i_b0 = 8'd6;
    wait_ack(1'b0, s_cyc, a_cyc, oth);
    check_eq("wd_start_cyc", 32'(s_cyc), 32'd1);
    check_eq("wd_ack_cyc", 32'(a_cyc), 32'd17);
    check_eq("wd_err", 32'(o_err), 32'd1);
    check_eq("wd_result", 32'(o_result), 32'd0);
    next_cycle();
    i_req0 = 1'b0;
    core_en = 1'b1;
    next_cycle();
    next_cycle();
    i_req0 = 1'b1; i_a0 = 8'd2; i_b0 = 8'd3;
    wait_ack(1'b0, s_cyc, a_cyc, oth);
    check_eq("wd_next_err", 32'(o_err), 32'd0);
    check_eq("wd_next_result", 32'(o_result), 32'd6);
    next_cycle();
    i_req0 = 1'b0;
    next_cycle();
    next_cycle();

    // Stray done in IDLE is ignored
    force_done = 1'b1;
    next_cycle();
    force_done = 1'b0;
    any_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("idle_done_busy%0d", k), 32'(o_busy), 32'd0);
      any_ack = any_ack | o_ack0 | o_ack1;
    end
    check_eq("idle_done_no_ack", 32'(any_ack), 32'd0);
    check_eq("idle_done_result", 32'(o_result), 32'd6);

    // Done on the abort cycle wins over the watchdog
    core_en = 1'b0;
    next_cycle();
    i_req0 = 1'b1; i_a0 = 8'd11; i_b0 = 8'd13;
    repeat (16) next_cycle();
    force_done = 1'b1;
    next_cycle();
    force_done = 1'b0;
    @(negedge clk);
    check_eq("late_done_ack", 32'(o_ack0), 32'd1);
    check_eq("late_done_err", 32'(o_err), 32'd0);
    check_eq("late_done_result", 32'(o_result), 32'd143);
    next_cycle();
    i_req0 = 1'b0;
    core_en = 1'b1;
    next_cycle();
    next_cycle();

    // Reset in the middle of WAIT
    i_req0 = 1'b1; i_a0 = 8'd9; i_b0 = 8'd9;
    repeat (4) next_cycle();
    #2;
    i_rst = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(o_busy), 32'd0);
    check_eq("midrst_result", 32'(o_result), 32'd0);
    check_eq("midrst_mul_ab", 32'({o_mul_a, o_mul_b}), 32'd0);
    check_eq("midrst_flags", 32'({o_ack0, o_ack1, o_err, o_grant_id, o_mul_start}), 32'd0);
    i_req0 = 1'b0;
    next_cycle();
    i_rst = 1'b0;
    any_ack = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      any_ack = any_ack | o_ack0 | o_ack1;
    end
    check_eq("midrst_no_ack", 32'(any_ack), 32'd0);
    next_cycle();
    i_req1 = 1'b1; i_a1 = 8'd4; i_b1 = 8'd4;
    wait_ack(1'b1, s_cyc, a_cyc, oth);
    check_eq("midrst_req1_ack", 32'(a_cyc >= 0), 32'd1);
    check_eq("midrst_req1_grant", 32'(o_grant_id), 32'd1);
    check_eq("midrst_req1_result", 32'(o_result), 32'd16);
    next_cycle();
    i_req1 = 1'b0;
    next_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one radix-4 multiplier core between two requesters (e.g. switch/button front-end and a test-pattern generator).
- Grants the core round-robin and latches the winner's operands.
- Sequences the core with a single-cycle start pulse, waits for its done, and returns the product with a one-cycle ack.
- Includes a watchdog that aborts a hung multiplication and flags an error.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH.
TIMEOUT, 16, max cycles in WAIT before abort; legal range 2..255.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req0  input  1  requester 0 level request; held until ack0, then dropped.
a0  input  WIDTH  requester 0 multiplicand, stable while req0=1.
b0  input  WIDTH  requester 0 multiplier, stable while req0=1.
req1  input  1  requester 1 level request.
a1  input  WIDTH  requester 1 multiplicand.
b1  input  WIDTH  requester 1 multiplier.
ack0  output  1  one-cycle pulse: result/err valid for requester 0.
ack1  output  1  one-cycle pulse: result/err valid for requester 1.
result  output  2*WIDTH  registered product; holds until next capture.
err  output  1  valid with ack: 1 = watchdog abort, result forced to 0.
busy  output  1  high in every state except IDLE.
grant_id  output  1  index of current/last granted requester.
mul_start  output  1  one-cycle start pulse to the multiplier core.
mul_a  output  WIDTH  latched multiplicand to the core.
mul_b  output  WIDTH  latched multiplier to the core.
mul_done  input  1  core completion; may be a pulse or a level.
mul_product  input  2*WIDTH  core product, valid while mul_done=1.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; all outputs 0; result=0; mul_a=mul_b=0.
  - Round-robin pointer prio=0 (requester 0 favoured); watchdog count=0.
  - A multiplication in flight is abandoned and no ack is issued.
- State machine states: IDLE, START, WAIT, RESP, RELEASE.
- IDLE:
  - No req: stay.
  - Only one req: grant it.
  - Both req: grant requester prio.
  - On the granting edge: grant_id<=winner; mul_a/mul_b<=winner's a/b; go START.
- START: mul_start=1 for exactly this cycle; watchdog count<=0; go WAIT.
- WAIT:
  - count increments each cycle.
  - mul_done=1: result<=mul_product, err<=0, go RESP.
  - Else if count==TIMEOUT-1: result<=0, err<=1, go RESP.
  - mul_done wins if both occur in the same cycle.
  - mul_done seen in IDLE, START, RESP or RELEASE is ignored.
- RESP:
  - ack[grant_id]=1 for one cycle; the other ack stays 0.
  - prio<=~grant_id.
  - Go RELEASE.
- RELEASE:
  - Wait until req[grant_id]=0, then go IDLE.
  - This prevents regranting a request already served.
  - Other requester's req is not sampled here.
- err holds its value until the next capture; result holds until the next capture.
- Operand latching: a/b changes after the grant edge do not affect mul_a/mul_b.
- Latency:
  - req rises in IDLE at cycle 0: mul_start at cycle 1.
  - mul_done first seen at cycle k (k≥2): ack at cycle k+1.
  - Minimum req-to-ack is 3 cycles.
- Fairness: with both requests continuously re-asserted after RELEASE, grants strictly alternate.
- Widths: no arithmetic on operands; product passes through at 2*WIDTH bits unmodified.

Test Plan:
All scenarios use WIDTH=8, TIMEOUT=16, and a core model that asserts mul_done for one cycle 4 cycles after mul_start.
- Single request: req0=1, a0=8'd7, b0=8'd9 → mul_start 1 cycle after grant; ack0 pulse 6 cycles after req0 rise; result=16'd63, err=0, ack1 never asserts. Drop req0 → busy=0 next cycle.
- Simultaneous requests from reset: req0=req1=1, (a0,b0)=(3,5), (a1,b1)=(255,255) → requester 0 served first (result=15), then requester 1 (result=16'hFE01, grant_id=1); requesters held high throughout produce alternation 0,1,0,1.
- Operand stability: change a0 to 8'd100 two cycles after grant → result still reflects the latched a0.
- Watchdog: core model never asserts mul_done → ack0 with err=1 and result=0 exactly TIMEOUT cycles after mul_start; next request completes normally with err=0.
- Late/early done: mul_done pulse in IDLE with no req → no state change, no ack. mul_done on the same cycle count reaches TIMEOUT-1 → err=0, product captured.
- Reset mid-operation: assert rst during WAIT → all outputs 0 immediately (async); after release, no ack for the aborted job; a new req1 is granted first (prio=0 but req0 low).
